// File: rtl/pin_entry.sv
// Keypad PIN collector: gathers four BCD digits with backspace/clear/enter
// editing, presents the completed PIN until acknowledged, and drops stale entries.
module pin_entry #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pin_ack,
  output logic [15:0] PIN,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic        entry_err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, SEND} state_e;

  localparam logic [3:0]  KEY_BSP    = 4'hA;
  localparam logic [3:0]  KEY_ENT    = 4'hB;
  localparam logic [3:0]  KEY_CLR    = 4'hC;
  localparam logic [25:0] TIMER_LAST = 26'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] pin_q, pin_d;
  logic [2:0]  count_q, count_d;
  logic [25:0] timer_q, timer_d;
  logic        entry_err_q, entry_err_d;
  logic        timeout_q, timeout_d;
  logic        key_acc;

  // Codes 0xD-0xF are dead keys: they neither edit nor count as activity.
  assign key_acc = key_valid && (key_code <= KEY_CLR);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    pin_d       = pin_q;
    count_d     = count_q;
    timer_d     = '0;
    entry_err_d = 1'b0;
    timeout_d   = 1'b0;

    if (state_q == SEND) begin
      if (pin_ack) begin
        state_d = IDLE;
        pin_d   = '0;
        count_d = '0;
      end
    end else if (key_acc) begin
      if (key_code <= 4'h9) begin
        if (count_q != 3'd4) begin
          pin_d   = {pin_q[11:0], key_code};
          count_d = count_q + 3'd1;
        end
      end else if (key_code == KEY_BSP) begin
        if (count_q != 3'd0) begin
          pin_d   = {4'h0, pin_q[15:4]};
          count_d = count_q - 3'd1;
        end
      end else if (key_code == KEY_ENT) begin
        if (count_q == 3'd4) begin
          state_d = SEND;
        end else begin
          entry_err_d = 1'b1;
          pin_d       = '0;
          count_d     = '0;
        end
      end else begin
        pin_d   = '0;
        count_d = '0;
      end

      // Editing states follow directly from how many digits remain held.
      if (state_d != SEND) begin
        if (count_d == 3'd0)      state_d = IDLE;
        else if (count_d == 3'd4) state_d = FULL;
        else                      state_d = ENTRY;
      end
    end else if (state_q != IDLE) begin
      if (timer_q == TIMER_LAST) begin
        timeout_d = 1'b1;
        pin_d     = '0;
        count_d   = '0;
        state_d   = IDLE;
      end else begin
        timer_d = timer_q + 26'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pin_q       <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      entry_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      entry_err_q <= entry_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign PIN         = pin_q;
  assign pin_valid   = (state_q == SEND);
  assign digit_count = count_q;
  assign entry_err   = entry_err_q;
  assign timeout     = timeout_q;

endmodule
